// File: rtl/sel_demux_collect.sv
// Registered 1-to-D_WIDTH demultiplexer and frame collector.
// Rebuilds the parallel word from serial bits, either by direct address or by auto-sequenced, double-buffered frames.
module sel_demux_collect #(
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned D_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 din,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 auto_mode,
    input  logic                 clear,
    output logic [D_WIDTH-1:0]   out,
    output logic                 upd,
    output logic                 frame_valid,
    output logic                 sel_err,
    output logic [SEL_WIDTH-1:0] ptr
);

    localparam int unsigned SW1 = SEL_WIDTH + 1;
    localparam logic [SW1-1:0]       D_LIM    = SW1'(D_WIDTH);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(D_WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]           state_q, state_nxt, state_cur;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_nxt, ptr_cur, idx;
    logic [D_WIDTH-1:0]   shadow_q, shadow_nxt, shadow_cur;
    logic [D_WIDTH-1:0]   out_q, out_nxt;
    logic                 upd_q, upd_nxt;
    logic                 fv_q, fv_nxt;
    logic                 err_q, err_nxt;
    logic                 mode_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            upd_q    <= 1'b0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ptr_q    <= ptr_nxt;
            shadow_q <= shadow_nxt;
            out_q    <= out_nxt;
            upd_q    <= upd_nxt;
            fv_q     <= fv_nxt;
            err_q    <= err_nxt;
            mode_q   <= auto_mode;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt  = state_q;
        ptr_nxt    = ptr_q;
        shadow_nxt = shadow_q;
        out_nxt    = out_q;
        upd_nxt    = 1'b0;
        fv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        idx        = '0;

        // A clear or a mode change drops any partial frame before this beat is used
        if (clear || (auto_mode != mode_q)) begin
            state_cur  = IDLE;
            ptr_cur    = '0;
            shadow_cur = '0;
        end else begin
            state_cur  = state_q;
            ptr_cur    = ptr_q;
            shadow_cur = shadow_q;
        end
        state_nxt  = state_cur;
        ptr_nxt    = ptr_cur;
        shadow_nxt = shadow_cur;

        if (!clear && in_valid) begin
            if (!auto_mode) begin
                if ({1'b0, sel} < D_LIM) begin
                    for (int i = 0; i < int'(D_WIDTH); i++) begin
                        if (sel == SEL_WIDTH'(i)) out_nxt[i] = din;
                    end
                    upd_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                case (state_cur)
                    IDLE:    idx = '0;
                    default: idx = ptr_cur;
                endcase
                if (idx == LAST_IDX) begin
                    out_nxt              = shadow_cur;
                    out_nxt[D_WIDTH-1]   = din;
                    fv_nxt               = 1'b1;
                    ptr_nxt              = '0;
                    shadow_nxt           = '0;
                    state_nxt            = IDLE;
                end else begin
                    for (int i = 0; i < int'(D_WIDTH); i++) begin
                        if (idx == SEL_WIDTH'(i)) shadow_nxt[i] = din;
                    end
                    ptr_nxt   = idx + SEL_WIDTH'(1);
                    state_nxt = FILL;
                end
            end
        end
    end

    assign out         = out_q;
    assign upd         = upd_q;
    assign frame_valid = fv_q;
    assign sel_err     = err_q;
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_sel_demux_collect.sv
// Self-checking bench for sel_demux_collect: a 4-bit and a 6-bit instance share stimulus
// and are compared against a bit-list reference model, with directed then random steps.
module tb_sel_demux_collect;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       din = 1'b0;
    logic       auto_mode = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] sel4 = '0;
    logic [2:0] sel6 = '0;

    logic [3:0] out4;
    logic       upd4, fv4, err4;
    logic [1:0] ptr4;
    logic [5:0] out6;
    logic       upd6, fv6, err6;
    logic [2:0] ptr6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sel_demux_collect #(.SEL_WIDTH(2), .D_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .sel(sel4),
        .auto_mode(auto_mode), .clear(clear), .out(out4), .upd(upd4),
        .frame_valid(fv4), .sel_err(err4), .ptr(ptr4)
    );

    sel_demux_collect #(.SEL_WIDTH(3), .D_WIDTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .sel(sel6),
        .auto_mode(auto_mode), .clear(clear), .out(out6), .upd(upd6),
        .frame_valid(fv6), .sel_err(err6), .ptr(ptr6)
    );

    // Reference model: collected bits kept as a list; a frame is published once D bits are in
    logic [7:0] m_out[2];
    bit         m_bits[2][8];
    int         m_cnt[2];
    bit         m_prev[2];
    bit         e_upd[2], e_fv[2], e_err[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = '0; m_cnt[k] = 0; m_prev[k] = 1'b0;
            e_upd[k] = 1'b0; e_fv[k] = 1'b0; e_err[k] = 1'b0;
        end
    endtask

    task automatic model_step(int k, int d, bit v, bit dn, int s, bit am, bit cl);
        e_upd[k] = 1'b0; e_fv[k] = 1'b0; e_err[k] = 1'b0;
        if (am != m_prev[k]) m_cnt[k] = 0;
        m_prev[k] = am;
        if (cl) begin
            m_cnt[k] = 0;
        end else if (v) begin
            if (!am) begin
                if (s < d) begin
                    m_out[k][s] = dn;
                    e_upd[k] = 1'b1;
                end else begin
                    e_err[k] = 1'b1;
                end
            end else begin
                m_bits[k][m_cnt[k]] = dn;
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == d) begin
                    m_out[k] = '0;
                    for (int i = 0; i < d; i++) m_out[k][i] = m_bits[k][i];
                    e_fv[k] = 1'b1;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("out4", 8'(out4), m_out[0]);
        chk("upd4", 8'(upd4), 8'(e_upd[0]));
        chk("fv4",  8'(fv4),  8'(e_fv[0]));
        chk("err4", 8'(err4), 8'(e_err[0]));
        chk("ptr4", 8'(ptr4), 8'(m_cnt[0]));
        chk("out6", 8'(out6), m_out[1]);
        chk("upd6", 8'(upd6), 8'(e_upd[1]));
        chk("fv6",  8'(fv6),  8'(e_fv[1]));
        chk("err6", 8'(err6), 8'(e_err[1]));
        chk("ptr6", 8'(ptr6), 8'(m_cnt[1]));
    endtask

    // Drive one cycle of inputs, advance the model, then sample just after the edge
    task automatic step(bit v, bit dn, int s4, int s6, bit am, bit cl);
        in_valid = v; din = dn; sel4 = 2'(s4); sel6 = 3'(s6);
        auto_mode = am; clear = cl;
        @(posedge clk);
        model_step(0, 4, v, dn, s4 & 3, am, cl);
        model_step(1, 6, v, dn, s6 & 7, am, cl);
        #1;
        chk_all();
    endtask

    task automatic idle_step(bit am);
        step(1'b0, 1'b0, 0, 0, am, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    bit pat_a[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit pat_b[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;

        // Addressed writes
        step(1'b1, 1'b1, 2, 2, 1'b0, 1'b0);
        chk("plan_addr1", 8'(out4), 8'h04);
        step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("plan_addr2", 8'(out4), 8'h05);
        step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        idle_step(1'b0);

        // Illegal selects on the 6-bit instance
        step(1'b1, 1'b1, 3, 7, 1'b0, 1'b0);
        chk("plan_selerr", 8'(err6), 8'h01);
        step(1'b1, 1'b1, 1, 6, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1, 5, 1'b0, 1'b0);

        // Auto frame 1,0,1,1
        step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        chk("plan_frame", 8'(out4), 8'h0D);
        idle_step(1'b1);

        // Gapped frame then back-to-back frame
        for (int b = 0; b < 4; b++) begin
            step(1'b1, pat_a[b], 0, 0, 1'b1, 1'b0);
            if (b < 3) begin idle_step(1'b1); idle_step(1'b1); end
        end
        chk("plan_gapped", 8'(out4), 8'h03);
        for (int b = 0; b < 4; b++) step(1'b1, pat_b[b], 0, 0, 1'b1, 1'b0);
        chk("plan_b2b", 8'(out4), 8'h0A);
        for (int b = 0; b < 8; b++) step(1'b1, b[0], 0, 0, 1'b1, 1'b0);

        // Abort with clear alongside a valid beat
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        chk("plan_abort", 8'(out4), 8'h0F);

        // Mode switch after three beats, beat in switch cycle is addressed
        for (int b = 0; b < 3; b++) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1, 1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        for (int b = 0; b < 5; b++) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);

        // Reset mid-frame, then a fresh frame from bit 0
        step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        async_reset();
        for (int b = 0; b < 6; b++) step(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit am;
            am = auto_mode;
            if ($urandom_range(0, 39) == 0) am = ~am;
            step($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), am, $urandom_range(0, 29) == 0);
            if (n == 300) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sel_demux_collect.md
# sel_demux_collect

Registered 1-to-D_WIDTH demultiplexer and frame collector: the inverse of the select-indexed D_WIDTH-to-1 bit multiplexer used on the same datapath. It takes a single serial data bit plus a select code and writes it into one bit of a registered output word. It supports either directly addressed writes or auto-sequenced frame assembly with a double-buffered output. It sits on the receive side of the mux path and rebuilds the parallel word the mux serialised.

## Interface
Parameters:
- SEL_WIDTH, default 2, width of the select code.
- D_WIDTH, default 4, width of the output word; must equal 2**SEL_WIDTH or less. Legal select values are 0..D_WIDTH-1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  din (and sel in addressed mode) is valid this cycle.
- din  input  1  serial data bit.
- sel  input  SEL_WIDTH  target bit index, used only in addressed mode.
- auto_mode  input  1  0 = addressed mode, 1 = auto-sequenced frame mode.
- clear  input  1  synchronous abort: empties the shadow register and returns the pointer to 0.
- out  output  D_WIDTH  registered output word.
- upd  output  1  one-cycle pulse: out changed because of an addressed write.
- frame_valid  output  1  one-cycle pulse: a complete auto-mode frame was loaded into out.
- sel_err  output  1  one-cycle pulse: an addressed write with sel >= D_WIDTH was dropped.
- ptr  output  SEL_WIDTH  current auto-mode fill pointer.

## Operation
- Reset (rst_n low, asynchronous): out=0, the shadow register=0, ptr=0, upd=0, frame_valid=0, sel_err=0, state IDLE.
- **Addressed mode** (auto_mode=0) with in_valid=1:
  - sel < D_WIDTH: out[sel] <= din; all other bits hold; upd=1 next cycle. upd pulses even if the value written is unchanged.
  - sel >= D_WIDTH: out is unchanged; sel_err=1 next cycle; upd=0.
- **Auto mode** (auto_mode=1), two-state FSM, IDLE (ptr=0, no partial frame) and FILL (ptr>0):
  - IDLE + in_valid: shadow[0] <= din, ptr <= 1, go to FILL.
  - FILL + in_valid with ptr < D_WIDTH-1: shadow[ptr] <= din, ptr <= ptr+1.
  - FILL + in_valid with ptr == D_WIDTH-1 (the last bit):
    - out <= shadow with bit D_WIDTH-1 replaced by din;
    - frame_valid=1 next cycle;
    - ptr <= 0 (wrap), go to IDLE;
    - shadow is cleared to 0.
  - in_valid=0: everything holds; gaps of any length between bits are allowed.
  - out changes only at frame completion; partial frames are never visible.
  - sel is ignored and sel_err never fires in this mode.
  - Special case D_WIDTH=1: every valid bit completes a frame directly from IDLE.
- **clear** (highest priority after reset):
  - shadow=0, ptr=0, state IDLE.
  - out is not modified.
  - An in_valid in the same cycle is discarded; no upd, frame_valid or sel_err.
- **auto_mode change**: any cycle where auto_mode differs from its value in the previous cycle behaves as clear for the auto-mode state. The in_valid in that cycle is then processed under the new mode. out holds across the change.
- upd, frame_valid and sel_err are mutually exclusive in any cycle.

## Timing
- Every output is registered.
- Latency is 1 cycle from an in_valid sample to the update of out, upd, frame_valid or sel_err.
- Auto-mode frame latency is D_WIDTH valid beats; frame_valid rises in the cycle after the last beat is sampled, coincident with the new out.
- Back-to-back frames with in_valid held high give one frame_valid every D_WIDTH cycles; there are no dead cycles.
- Reset asserted mid-frame aborts immediately; the first in_valid after release starts a new frame at bit 0.

## Test plan
- Reset and addressed writes: after reset, out=0000. Send sel=2,din=1 then sel=0,din=1 -> out=0100, then out=0101; upd pulses on each of the two cycles.
- Illegal select: SEL_WIDTH=3, D_WIDTH=6, sel=7, din=1 -> out unchanged, sel_err=1 for one cycle, upd=0.
- Auto frame: auto_mode=1, din sequence 1,0,1,1 with in_valid high every cycle -> out=1101 (bit0=1) and frame_valid for one cycle, one cycle after the 4th beat; out unchanged during beats 1-3; ptr goes 0,1,2,3,0.
- Gapped and back-to-back frames: bits 1,1,0,0 with 2-cycle in_valid gaps, then bits 0,1,0,1 continuously -> out=0011 then 1010, with exactly two frame_valid pulses.
- Abort: after 2 auto beats, assert clear together with in_valid -> ptr=0, no pulses, out unchanged. The next 4 beats 1,1,1,1 -> out=1111.
- Mode switch and reset mid-frame: toggle auto_mode after 3 beats -> partial frame discarded, out held. Drop rst_n mid-frame -> out=0 and ptr=0 immediately, without waiting for a clock edge.
